// File: rtl/sbus_pkg.sv
// Shared constants and types for the SBUS multiplier master: peripheral
// register map, status bit positions, access phases and job states.
package sbus_pkg;

    localparam logic [15:0] ADDR_ARG1 = 16'h037F;
    localparam logic [15:0] ADDR_ARG2 = 16'h0388;
    localparam logic [15:0] ADDR_CTRL = 16'h03A0;
    localparam logic [15:0] ADDR_RES  = 16'h0390;
    localparam logic [15:0] ADDR_ONES = 16'h0398;

    localparam int STAT_READY = 1;
    localparam int STAT_VALID = 0;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_STROBE = 2'd2,
        PH_HOLD   = 2'd3
    } phase_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_A1   = 4'd1,
        ST_WR_A2   = 4'd2,
        ST_WR_CTRL = 4'd3,
        ST_SETTLE  = 4'd4,
        ST_RD_STAT = 4'd5,
        ST_RD_RES  = 4'd6,
        ST_RD_ONES = 4'd7,
        ST_DONE    = 4'd8
    } state_e;

    // Zero-extend a 24-bit multiplicand to the 32-bit bus width.
    function automatic logic [31:0] pad_arg(input logic [23:0] a);
        return {8'h00, a};
    endfunction

endpackage

// File: rtl/sbus_access.sv
// Single-access engine: SETUP / STROBE / HOLD, one clock each. A request is
// accepted while idle or in the last (HOLD) clock of the previous access so
// accesses can run back to back. ack is high during HOLD; rdata is the
// live bus read data, meant to be captured on the edge that ends HOLD.
module sbus_access
    import sbus_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    phase_e      phase_q, phase_d;
    logic        we_q, we_d;
    logic [15:0] saddress_q, saddress_d;
    logic [31:0] sdata_out_q, sdata_out_d;
    logic        srd_q, srd_d;
    logic        swr_q, swr_d;
    logic        accept_s;

    assign accept_s  = req && ((phase_q == PH_IDLE) || (phase_q == PH_HOLD));
    assign ack       = (phase_q == PH_HOLD);
    assign rdata     = sdata_in;
    assign saddress  = saddress_q;
    assign sdata_out = sdata_out_q;
    assign srd       = srd_q;
    assign swr       = swr_q;

    // Phase sequencing; strobes are only ever raised for the STROBE clock.
    always_comb begin
        phase_d     = phase_q;
        we_d        = we_q;
        saddress_d  = saddress_q;
        sdata_out_d = sdata_out_q;
        srd_d       = 1'b0;
        swr_d       = 1'b0;
        case (phase_q)
            PH_IDLE, PH_HOLD: begin
                if (accept_s) begin
                    phase_d     = PH_SETUP;
                    we_d        = we;
                    saddress_d  = addr;
                    sdata_out_d = wdata;
                end else begin
                    phase_d = PH_IDLE;
                end
            end
            PH_SETUP: begin
                phase_d = PH_STROBE;
                srd_d   = ~we_q;
                swr_d   = we_q;
            end
            PH_STROBE: begin
                phase_d = PH_HOLD;
            end
            default: begin
                phase_d = PH_IDLE;
            end
        endcase
    end

    // Register all bus-facing outputs; reset clears them at once.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            phase_q     <= PH_IDLE;
            we_q        <= 1'b0;
            saddress_q  <= 16'h0000;
            sdata_out_q <= 32'h0000_0000;
            srd_q       <= 1'b0;
            swr_q       <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            we_q        <= we_d;
            saddress_q  <= saddress_d;
            sdata_out_q <= sdata_out_d;
            srd_q       <= srd_d;
            swr_q       <= swr_d;
        end
    end

endmodule

// File: rtl/sbus_mult_master.sv
// Job sequencer for the SBUS multiplier peripheral: writes both operands and
// the control word, waits a settle time, polls status, then reads result and
// set-bit count. All strobe timing lives in sbus_access.
module sbus_mult_master
    import sbus_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int POLL_LIMIT    = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [23:0] arg1,
    input  logic [23:0] arg2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [23:0] ones,
    output logic        overflow,
    output logic        timeout,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    // A poll limit of zero still allows one status read.
    localparam logic [8:0]  POLL_LIM    = 9'((POLL_LIMIT == 0) ? 1 : POLL_LIMIT);
    localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit          NO_SETTLE   = (SETTLE_CYCLES == 0);

    state_e      state_q, state_d;
    logic [23:0] arg2_q, arg2_d;
    logic [15:0] settle_cnt_q, settle_cnt_d;
    logic [7:0]  poll_cnt_q, poll_cnt_d;
    logic [8:0]  poll_next_s;
    logic        busy_q, busy_d, done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [23:0] ones_q, ones_d;
    logic        overflow_q, overflow_d, timeout_q, timeout_d;

    logic        acc_req_s, acc_we_s, acc_ack_s;
    logic [15:0] acc_addr_s;
    logic [31:0] acc_wdata_s, acc_rdata_s;

    assign poll_next_s = {1'b0, poll_cnt_q} + 9'd1;

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign ones     = ones_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

    sbus_access u_access (
        .clk       (clk),
        .n_reset   (n_reset),
        .req       (acc_req_s),
        .we        (acc_we_s),
        .addr      (acc_addr_s),
        .wdata     (acc_wdata_s),
        .ack       (acc_ack_s),
        .rdata     (acc_rdata_s),
        .saddress  (saddress),
        .srd       (srd),
        .swr       (swr),
        .sdata_out (sdata_out),
        .sdata_in  (sdata_in)
    );

    // Next-state logic; each access is requested on the edge that enters its state.
    always_comb begin
        state_d      = state_q;
        arg2_d       = arg2_q;
        settle_cnt_d = settle_cnt_q;
        poll_cnt_d   = poll_cnt_q;
        result_d     = result_q;
        ones_d       = ones_q;
        overflow_d   = overflow_q;
        timeout_d    = timeout_q;
        acc_req_s    = 1'b0;
        acc_we_s     = 1'b0;
        acc_addr_s   = 16'h0000;
        acc_wdata_s  = 32'h0000_0000;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WR_A1;
                    arg2_d      = arg2;
                    poll_cnt_d  = 8'd0;
                    overflow_d  = 1'b0;
                    timeout_d   = 1'b0;
                    acc_req_s   = 1'b1;
                    acc_we_s    = 1'b1;
                    acc_addr_s  = ADDR_ARG1;
                    acc_wdata_s = pad_arg(arg1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_A1: begin
                if (acc_ack_s) begin
                    state_d     = ST_WR_A2;
                    acc_req_s   = 1'b1;
                    acc_we_s    = 1'b1;
                    acc_addr_s  = ADDR_ARG2;
                    acc_wdata_s = pad_arg(arg2_q);
                end else begin
                    state_d = ST_WR_A1;
                end
            end
            ST_WR_A2: begin
                if (acc_ack_s) begin
                    state_d     = ST_WR_CTRL;
                    acc_req_s   = 1'b1;
                    acc_we_s    = 1'b1;
                    acc_addr_s  = ADDR_CTRL;
                    acc_wdata_s = 32'h0000_0001;
                end else begin
                    state_d = ST_WR_A2;
                end
            end
            ST_WR_CTRL: begin
                if (acc_ack_s && NO_SETTLE) begin
                    state_d    = ST_RD_STAT;
                    acc_req_s  = 1'b1;
                    acc_addr_s = ADDR_CTRL;
                end else if (acc_ack_s) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = 16'd0;
                end else begin
                    state_d = ST_WR_CTRL;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d    = ST_RD_STAT;
                    acc_req_s  = 1'b1;
                    acc_addr_s = ADDR_CTRL;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            ST_RD_STAT: begin
                if (acc_ack_s && !acc_rdata_s[STAT_READY]) begin
                    state_d    = ST_RD_RES;
                    overflow_d = ~acc_rdata_s[STAT_VALID];
                    acc_req_s  = 1'b1;
                    acc_addr_s = ADDR_RES;
                end else if (acc_ack_s && (poll_next_s >= POLL_LIM)) begin
                    state_d    = ST_DONE;
                    poll_cnt_d = poll_next_s[7:0];
                    timeout_d  = 1'b1;
                end else if (acc_ack_s) begin
                    poll_cnt_d = poll_next_s[7:0];
                    acc_req_s  = 1'b1;
                    acc_addr_s = ADDR_CTRL;
                end else begin
                    state_d = ST_RD_STAT;
                end
            end
            ST_RD_RES: begin
                if (acc_ack_s) begin
                    state_d    = ST_RD_ONES;
                    result_d   = acc_rdata_s;
                    acc_req_s  = 1'b1;
                    acc_addr_s = ADDR_ONES;
                end else begin
                    state_d = ST_RD_RES;
                end
            end
            ST_RD_ONES: begin
                if (acc_ack_s) begin
                    state_d = ST_DONE;
                    ones_d  = acc_rdata_s[23:0];
                end else begin
                    state_d = ST_RD_ONES;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Job state and registered status outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            arg2_q       <= 24'h000000;
            settle_cnt_q <= 16'd0;
            poll_cnt_q   <= 8'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= 32'h0000_0000;
            ones_q       <= 24'h000000;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg2_q       <= arg2_d;
            settle_cnt_q <= settle_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
            ones_q       <= ones_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sbus_mult_master.sv
// Bench for sbus_mult_master: behavioural peripheral, bus protocol checker,
// a table of directed jobs, a reset-during-strobe sequence and random jobs.
module tb_sbus_mult_master;

    localparam int SETTLE = 8;
    localparam int PLIM   = 4;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic [23:0] arg1 = 24'h0, arg2 = 24'h0;
    logic        busy, done, overflow, timeout, srd, swr;
    logic [31:0] result, sdata_out;
    logic [31:0] sdata_in = 32'h0;
    logic [23:0] ones;
    logic [15:0] saddress;

    int n_cmp = 0;
    int n_err = 0;

    sbus_mult_master #(.SETTLE_CYCLES(SETTLE), .POLL_LIMIT(PLIM)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .arg1(arg1), .arg2(arg2),
        .busy(busy), .done(done), .result(result), .ones(ones),
        .overflow(overflow), .timeout(timeout), .saddress(saddress),
        .srd(srd), .swr(swr), .sdata_out(sdata_out), .sdata_in(sdata_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural peripheral ----------------
    logic [31:0] reg_a1 = 32'h0, reg_a2 = 32'h0, p_res = 32'h0;
    int          poll_idx = 0;
    int          cfg_polls = 0;
    logic [31:0] cfg_fin = 32'h1;
    int          n_acc = 0, n_stat = 0;
    logic [63:0] prod_s;

    assign prod_s = {32'h0, reg_a1} * {32'h0, reg_a2};

    always @(posedge clk) begin
        if (swr) begin
            n_acc <= n_acc + 1;
            case (saddress)
                16'h037F: reg_a1 <= sdata_out;
                16'h0388: reg_a2 <= sdata_out;
                16'h03A0: if (sdata_out == 32'h1) begin poll_idx <= 0; p_res <= prod_s[31:0]; end
                default: ;
            endcase
        end
        if (srd) begin
            n_acc <= n_acc + 1;
            case (saddress)
                16'h03A0: begin
                    n_stat   <= n_stat + 1;
                    poll_idx <= poll_idx + 1;
                    sdata_in <= (poll_idx < cfg_polls) ? 32'h3 : cfg_fin;
                end
                16'h0390: sdata_in <= p_res;
                16'h0398: sdata_in <= {8'h00, 24'($countones(p_res))};
                default:  sdata_in <= 32'hDEAD_BEEF;
            endcase
        end
    end

    // ---------------- bus protocol checker ----------------
    logic        p_srd = 1'b0, p_swr = 1'b0;
    logic [15:0] p_addr = 16'h0;
    always @(negedge clk or negedge n_reset) begin
        if (!n_reset) begin
            p_srd = 1'b0; p_swr = 1'b0; p_addr = 16'h0;
        end else begin
            if (srd || swr) begin
                chk("strobe_excl", 64'(srd & swr), 64'd0);
                chk("strobe_width", 64'((srd & p_srd) | (swr & p_swr)), 64'd0);
                chk("addr_setup_strobe", 64'(saddress), 64'(p_addr));
            end
            if (p_srd || p_swr) chk("addr_hold", 64'(saddress), 64'(p_addr));
            p_srd = srd; p_swr = swr; p_addr = saddress;
        end
    end

    // ---------------- job vectors and expectation model ----------------
    typedef struct {
        logic [23:0] a1, a2;
        logic [31:0] fin;
        int          polls;
        int          poke;
        logic [31:0] exp_res;
        logic [23:0] exp_ones;
        logic        exp_ovf, exp_to;
        int          exp_lat;
    } vec_t;

    logic [31:0] prev_res = 32'h0;
    logic [23:0] prev_ones = 24'h0;

    // Expected outcome from the job rules: three writes, settle, (polls+1)
    // status reads on success or PLIM reads on timeout, then two result reads.
    function automatic vec_t make_vec(input logic [23:0] a1, input logic [23:0] a2,
                                      input logic [31:0] fin, input int polls, input int poke);
        vec_t v;
        logic [47:0] p;
        p = 48'(a1) * 48'(a2);
        v.a1 = a1; v.a2 = a2; v.fin = fin; v.polls = polls; v.poke = poke;
        v.exp_to   = (polls >= PLIM);
        v.exp_res  = v.exp_to ? prev_res : p[31:0];
        v.exp_ones = v.exp_to ? prev_ones : 24'($countones(p[31:0]));
        v.exp_ovf  = v.exp_to ? 1'b0 : ~fin[0];
        v.exp_lat  = v.exp_to ? (10 + SETTLE + 3 * PLIM) : (19 + SETTLE + 3 * polls);
        return v;
    endfunction

    task automatic run_job(input vec_t v);
        int cyc, acc0, stat0, exp_acc, exp_stat;
        acc0 = n_acc; stat0 = n_stat;
        exp_stat = v.exp_to ? PLIM : v.polls + 1;
        exp_acc  = 3 + exp_stat + (v.exp_to ? 0 : 2);
        @(negedge clk);
        arg1 = v.a1; arg2 = v.a2; cfg_polls = v.polls; cfg_fin = v.fin; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cyc = 1;
        chk("busy_rise", 64'(busy), 64'd1);
        chk("first_setup_addr", 64'(saddress), 64'h037F);
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (cyc == v.poke);
        end
        start = 1'b0;
        chk("done_latency", 64'(cyc), 64'(v.exp_lat));
        chk("busy_with_done", 64'(busy), 64'd1);
        chk("result", 64'(result), 64'(v.exp_res));
        chk("ones", 64'(ones), 64'(v.exp_ones));
        chk("overflow", 64'(overflow), 64'(v.exp_ovf));
        chk("timeout", 64'(timeout), 64'(v.exp_to));
        chk("access_count", 64'(n_acc - acc0), 64'(exp_acc));
        chk("status_reads", 64'(n_stat - stat0), 64'(exp_stat));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        end
        chk("result_hold", 64'(result), 64'(v.exp_res));
        prev_res = v.exp_res; prev_ones = v.exp_ones;
    endtask

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t v;
        int   found;
        // {a1, a2, fin, polls, poke, exp_res, exp_ones, exp_ovf, exp_to, exp_lat}
        tbl[0] = '{24'h000003, 24'h000005, 32'h1, 0, -1, 32'h0000000F, 24'd4, 1'b0, 1'b0, 27};
        tbl[1] = '{24'hFFFFFF, 24'hFFFFFF, 32'h0, 0, -1, 32'hFE000001, 24'd8, 1'b1, 1'b0, 27};
        tbl[2] = '{24'h000007, 24'h000009, 32'h1, 2,  4, 32'h0000003F, 24'd6, 1'b0, 1'b0, 33};
        tbl[3] = '{24'h000010, 24'h000010, 32'h1, 9, -1, 32'h0000003F, 24'd6, 1'b0, 1'b1, 30};
        tbl[4] = '{24'h123456, 24'h000002, 32'h1, 1, -1, 32'h002468AC, 24'd9, 1'b0, 1'b0, 30};

        repeat (3) @(negedge clk);
        chk("reset_state", {busy, done, overflow, timeout, srd, swr, saddress, ones}, 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        n_reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_job(tbl[i]);

        // Reset asserted during the STROBE clock of the control write.
        @(negedge clk);
        arg1 = 24'd3; arg2 = 24'd5; cfg_polls = 0; cfg_fin = 32'h1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (swr && saddress == 16'h03A0) found = 1;
            else @(negedge clk);
        end
        chk("ctrl_strobe_seen", 64'(found), 64'd1);
        #1 n_reset = 1'b0;
        #1;
        chk("rst_swr_drop", 64'(swr), 64'd0);
        chk("rst_bus", {14'd0, saddress, srd, swr, sdata_out}, 64'd0);
        chk("rst_status", {36'd0, busy, done, overflow, timeout, ones}, 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_resume", {61'd0, busy, srd, swr}, 64'd0);
        end
        prev_res = 32'h0; prev_ones = 24'h0;
        run_job(make_vec(24'd3, 24'd5, 32'h1, 0, -1));

        // Random jobs against the expectation model.
        for (int i = 0; i < 20; i++) begin
            v = make_vec(24'($urandom), 24'($urandom), 32'($urandom_range(0, 1)),
                         int'($urandom_range(0, 5)), int'($urandom_range(2, 12)));
            run_job(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
